// File: rtl/resp_pkg.sv
// resp_pkg: FSM states and defaults shared by resp_encode and its gap timer
package resp_pkg;
  typedef enum logic [2:0] {IDLE, HDR, POP, RDWAIT, GAP} state_t;
  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hAA;
  localparam int DEFAULT_GAP_CYCLES = 52090;
  function automatic int cnt_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/resp_encode_if.sv
// resp_encode_if: read-FIFO and uart_tx side signals of resp_encode
interface resp_encode_if;
  logic rfifo_empty;
  logic [7:0] rfifo_dout;
  logic rfifo_rd_en;
  logic tx_trig;
  logic [7:0] tx_data;
  logic busy;
  logic frame_done;
  modport master(input rfifo_empty, rfifo_dout, output rfifo_rd_en, tx_trig, tx_data, busy, frame_done);
  modport slave(output rfifo_empty, rfifo_dout, input rfifo_rd_en, tx_trig, tx_data, busy, frame_done);
endinterface

// File: rtl/tx_gap_timer.sv
// tx_gap_timer: counts 0..GAP_CYCLES-1 after load; done flags the terminal count, pre the count before it
module tx_gap_timer import resp_pkg::*; #(
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done,
  output logic pre
);
  localparam int W = cnt_width(GAP_CYCLES);
  localparam logic [W-1:0] LAST = W'(GAP_CYCLES - 1);
  logic [W-1:0] gap_cnt;
  always_ff @(posedge clk)
    if (rst) gap_cnt <= '0;
    else if (load) gap_cnt <= '0;
    else if (gap_cnt != LAST) gap_cnt <= gap_cnt + 1'b1;
  assign done = gap_cnt == LAST;
  assign pre = GAP_CYCLES > 1 && gap_cnt == W'(GAP_CYCLES - 2);
endmodule

// File: rtl/resp_encode.sv
// resp_encode: drains the read FIFO and paces bytes into uart_tx as response frames.
// Define RESP_HDR_EN to prefix every frame with HDR_BYTE.
module resp_encode import resp_pkg::*; #(
  parameter int RD_LEN = 1,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
  input logic sclk,
  input logic rst,
  resp_encode_if.master io
);
`ifdef RESP_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  state_t state, state_d;
  logic [7:0] byte_cnt, byte_d, data_d;
  logic hdr_sent, hdr_d, trig_d, fd_d, done, pre, last;
  tx_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_timer (.clk(sclk), .rst(rst), .load(trig_d), .done(done), .pre(pre));
  assign last = byte_cnt == 8'(RD_LEN);
  always_comb begin
    state_d = state;
    byte_d = byte_cnt;
    hdr_d = hdr_sent;
    trig_d = 1'b0;
    data_d = io.tx_data;
    case (state)
      IDLE: state_d = io.rfifo_empty ? IDLE : (HDR_EN && byte_cnt == '0 && !hdr_sent) ? HDR : POP;
      HDR: begin
        state_d = GAP;
        trig_d = 1'b1;
        data_d = HDR_BYTE;
        hdr_d = 1'b1;
      end
      POP: state_d = RDWAIT;
      RDWAIT: begin
        state_d = GAP;
        trig_d = 1'b1;
        data_d = io.rfifo_dout;
        byte_d = byte_cnt + 1'b1;
      end
      GAP: if (done) begin
        state_d = (last || io.rfifo_empty) ? IDLE : POP;
        byte_d = last ? '0 : byte_cnt;
        hdr_d = last ? 1'b0 : hdr_sent;
      end
      default: state_d = IDLE;
    endcase
    // frame_done is raised so it lands on the terminal gap count of the frame's last byte
    fd_d = byte_d == 8'(RD_LEN) && (trig_d ? GAP_CYCLES == 1 : state == GAP && !done && pre);
  end
  always_ff @(posedge sclk)
    if (rst) begin
      state <= IDLE;
      byte_cnt <= '0;
      hdr_sent <= 1'b0;
      io.rfifo_rd_en <= 1'b0;
      io.tx_trig <= 1'b0;
      io.tx_data <= '0;
      io.busy <= 1'b0;
      io.frame_done <= 1'b0;
    end else begin
      state <= state_d;
      byte_cnt <= byte_d;
      hdr_sent <= hdr_d;
      io.rfifo_rd_en <= state_d == POP;
      io.tx_trig <= trig_d;
      io.tx_data <= data_d;
      io.busy <= state_d != IDLE;
      io.frame_done <= fd_d;
    end
endmodule

// File: tb/tb_resp_encode.sv
// tb_resp_encode: directed and random frames checked against a byte-stream and timing reference model
module tb_resp_encode;
  localparam int GAP = 8, RD_LEN = 3;
`ifdef RESP_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  logic sclk = 1'b0, rst = 1'b1;
  resp_encode_if bus();
  resp_encode #(.RD_LEN(RD_LEN), .GAP_CYCLES(GAP)) dut (.sclk(sclk), .rst(rst), .io(bus));
  always #5 sclk = ~sclk;
  logic [7:0] mem [0:1023];
  int pushes = 0, pops = 0;
  assign bus.rfifo_empty = pushes == pops;
  always @(posedge sclk)
    if (bus.rfifo_rd_en) begin
      bus.rfifo_dout <= mem[pops];
      pops <= pops + 1;
    end
  int total = 0, bad = 0, cyc = 0, last_rd = -100, fd_due = -1, fb = 0;
  int n_rd = 0, n_trig = 0, n_fd = 0, n_data = 0;
  bit hdr_seen = 1'b0;
  int trig_t[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] b);
    mem[pushes] = b;
    pushes++;
  endtask
  // reference model: data bytes leave in push order, a header opens each frame when enabled,
  // a pop precedes each data trigger by 2 clocks, frame_done sits GAP-1 clocks after the last byte
  task automatic tick();
    logic hdr;
    logic [7:0] want;
    @(negedge sclk);
    cyc++;
    if (rst) begin
      fb = 0;
      hdr_seen = 1'b0;
      fd_due = -1;
    end else begin
      if (bus.rfifo_rd_en) begin
        check("rd_nonempty", 32'(pushes != pops), 1);
        last_rd = cyc;
        n_rd++;
      end
      if (bus.tx_trig) begin
        hdr = HDR_EN && fb == 0 && !hdr_seen;
        want = hdr ? 8'hAA : mem[n_data];
        if (!hdr) begin
          check("data_pending", 32'(n_data < pushes), 1);
          check("rd_to_trig", cyc - last_rd, 2);
          n_data++;
          fb++;
        end
        check("tx_data", 32'(bus.tx_data), 32'(want));
        hdr_seen = hdr_seen | hdr;
        trig_t.push_back(cyc);
        n_trig++;
        if (fb == RD_LEN) begin
          fd_due = cyc + GAP - 1;
          fb = 0;
          hdr_seen = 1'b0;
        end
      end
      if (bus.frame_done) n_fd++;
      check("frame_done", 32'(bus.frame_done), 32'(cyc == fd_due));
    end
  endtask
  task automatic wait_fd(input string tag);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.frame_done) break;
    end
    check(tag, 32'(bus.frame_done), 1);
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_rd_en"}, 32'(bus.rfifo_rd_en), 0);
    check({tag, "_trig"}, 32'(bus.tx_trig), 0);
    check({tag, "_data"}, 32'(bus.tx_data), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_fd"}, 32'(bus.frame_done), 0);
  endtask
  initial begin
    bit any_rd, any_trig, any_busy;
    int base, k, nf, cnt;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    any_rd = 0; any_trig = 0; any_busy = 0;
    repeat (1000) begin
      tick();
      any_rd |= bus.rfifo_rd_en;
      any_trig |= bus.tx_trig;
      any_busy |= bus.busy;
    end
    check("empty_rd_en", 32'(any_rd), 0);
    check("empty_trig", 32'(any_trig), 0);
    check("empty_busy", 32'(any_busy), 0);
    base = trig_t.size(); k = n_rd; nf = n_fd;
    repeat (RD_LEN) push(8'($urandom));
    wait_fd("burst_fd");
    check("burst_pops", n_rd - k, RD_LEN);
    check("burst_trigs", trig_t.size() - base, RD_LEN + int'(HDR_EN));
    for (int i = base + 1; i < trig_t.size(); i++) check("burst_spacing", trig_t[i] - trig_t[i-1], GAP + 2);
    tick();
    check("burst_busy_low", 32'(bus.busy), 0);
    check("burst_frames", n_fd - nf, 1);
    nf = n_fd; base = n_trig;
    push(8'($urandom));
    repeat (50) tick();
    check("uf_busy", 32'(bus.busy), 0);
    check("uf_no_fd", n_fd - nf, 0);
    repeat (RD_LEN - 1) push(8'($urandom));
    wait_fd("uf_fd");
    check("uf_frames", n_fd - nf, 1);
    check("uf_trigs", n_trig - base, RD_LEN + int'(HDR_EN));
    base = n_data;
    repeat (2) push(8'($urandom));
    for (int i = 0; i < 200; i++) begin
      tick();
      if (n_data - base == 2) break;
    end
    check("rst_second_trig", n_data - base, 2);
    rst = 1'b1;
    tick();
    check_idle("midrst");
    rst = 1'b0;
    base = n_trig; nf = n_fd;
    repeat (30) tick();
    check("rst_quiet_trig", n_trig - base, 0);
    check("rst_quiet_busy", 32'(bus.busy), 0);
    repeat (RD_LEN) push(8'($urandom));
    wait_fd("rst_new_fd");
    check("rst_frames", n_fd - nf, 1);
    check("rst_trigs", n_trig - base, RD_LEN + int'(HDR_EN));
    nf = n_fd; cnt = 0;
    repeat (6) begin
      k = $urandom_range(1, 4);
      repeat (k) push(8'($urandom));
      cnt += k;
      repeat ($urandom_range(0, 40)) tick();
    end
    while (cnt % RD_LEN != 0) begin
      push(8'($urandom));
      cnt++;
    end
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (n_data == pushes && !bus.busy) break;
    end
    check("rnd_drained", n_data, pushes);
    check("rnd_busy", 32'(bus.busy), 0);
    check("rnd_frames", n_fd - nf, cnt / RD_LEN);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
